sps_burst_ctrl: RTL

//  Burst sequencer for the SPS serialiser datapath: reads burst_len consecutive MRAM words from start_addr and

---
 rtl/sps_burst_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sps_burst_ctrl.sv
// sps_burst_ctrl: sequences MRAM word reads into the parallel-to-serial shifter, one burst at a time
module sps_burst_ctrl #(
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 8,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic [1:0]            word_sel_cfg,
    input  logic                  abort,
    output logic                  mram_re,
    output logic [ADDR_WIDTH-1:0] mram_addr,
    output logic                  p2s_en,
    output logic                  p2s_load,
    output logic                  p2s_send,
    output logic [1:0]            p2s_word_sel,
    output logic                  bit_valid,
    output logic                  busy,
    output logic                  word_done,
    output logic                  done,
    output logic                  err
);
    localparam int CW       = $clog2(BUS_WIDTH) + 1;
    localparam int WAIT_CYC = (RD_LAT > 1) ? RD_LAT - 1 : 0;
    localparam int WW       = $clog2(RD_LAT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);
    localparam logic [CW-1:0] NB_FULL   = CW'(BUS_WIDTH);
    localparam logic [CW-1:0] NB_HALF   = CW'(BUS_WIDTH / 2);

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, LOAD, SHIFT, NEXT, DONE} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [LEN_WIDTH-1:0]  left_q, left_n;
    logic [CW-1:0]         bit_q, bit_n;
    logic [WW-1:0]         wait_q, wait_n;
    logic [1:0]            sel_n;
    logic [CW-1:0]         nb;
    logic                  err_n, done_n;

    assign nb = (p2s_word_sel == 2'b11) ? NB_FULL : NB_HALF;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= state_n;
    end

    // Next-state, counter and command-latch decisions; abort from any active state wins
    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        left_n  = left_q;
        bit_n   = bit_q;
        wait_n  = wait_q;
        sel_n   = p2s_word_sel;
        err_n   = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (word_sel_cfg == 2'b00) err_n = 1'b1;
                    else if (burst_len == '0) done_n = 1'b1;
                    else begin
                        state_n = ADDR;
                        addr_n  = start_addr;
                        left_n  = burst_len;
                        sel_n   = word_sel_cfg;
                    end
                end
            end
            ADDR: begin
                state_n = (WAIT_CYC == 0) ? LOAD : WAIT;
                wait_n  = '0;
            end
            WAIT: begin
                wait_n  = wait_q + WW'(1);
                state_n = (wait_q == WAIT_LAST) ? LOAD : WAIT;
            end
            LOAD: begin
                state_n = SHIFT;
                bit_n   = '0;
            end
            SHIFT: begin
                bit_n   = bit_q + CW'(1);
                state_n = (bit_q == nb - CW'(1)) ? NEXT : SHIFT;
            end
            NEXT: begin
                if (left_q > LEN_WIDTH'(1)) begin
                    left_n  = left_q - LEN_WIDTH'(1);
                    addr_n  = addr_q + ADDR_WIDTH'(1);
                    state_n = ADDR;
                end else state_n = DONE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (state != IDLE && abort) state_n = IDLE;
    end

    // Counters, latched config and registered outputs decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q       <= '0;
            left_q       <= '0;
            bit_q        <= '0;
            wait_q       <= '0;
            p2s_word_sel <= 2'b00;
            mram_re      <= 1'b0;
            mram_addr    <= '0;
            p2s_en       <= 1'b0;
            p2s_load     <= 1'b0;
            p2s_send     <= 1'b0;
            bit_valid    <= 1'b0;
            busy         <= 1'b0;
            word_done    <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            addr_q       <= addr_n;
            left_q       <= left_n;
            bit_q        <= bit_n;
            wait_q       <= wait_n;
            p2s_word_sel <= sel_n;
            mram_re      <= state_n == ADDR;
            mram_addr    <= (state_n == ADDR) ? addr_n : '0;
            p2s_en       <= state_n != IDLE;
            p2s_load     <= state_n == LOAD;
            p2s_send     <= state_n == SHIFT;
            bit_valid    <= p2s_send;
            busy         <= state_n != IDLE;
            word_done    <= state_n == NEXT;
            done         <= done_n || state_n == DONE;
            err          <= err_n;
        end
    end
endmodule
